// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wshb_arb_pkg;
  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_M0   = 2'b01,
    GNT_M1   = 2'b10
  } gnt_t;

  localparam int NB_MASTERS = 2;
endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle; master drives the request, slave drives the response.
interface wshb_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADR_W      = 32
);
  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [ADR_W-1:0]          adr;
  logic [DATA_BYTES-1:0]     sel;
  logic [8*DATA_BYTES-1:0]   dat_ms;
  logic [8*DATA_BYTES-1:0]   dat_sm;
  logic [2:0]                cti;
  logic [1:0]                bte;
  logic                      ack;
  logic                      err;
  logic                      rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wshb_arb_pick.sv
// Combinational grant decision: who gets the bus given the current requests.
module wshb_arb_pick
  import wshb_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [NB_MASTERS-1:0] i_req,
  input  logic                  i_last_served,
  output gnt_t                  o_gnt
);

  always_comb begin
    o_gnt = GNT_IDLE;
    case (i_req)
      2'b01:   o_gnt = GNT_M0;
      2'b10:   o_gnt = GNT_M1;
      // Contested: fixed priority favours master 0, otherwise alternate
      2'b11:   o_gnt = (FIXED_PRIO || i_last_served) ? GNT_M0 : GNT_M1;
      default: o_gnt = GNT_IDLE;
    endcase
  end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master to one-slave Wishbone arbiter; grant is held for the owner's whole cycle.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int DATA_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      wshb_ifs0,
  wshb_if.slave      wshb_ifs1,
  wshb_if.master     wshb_ifm,
  output logic [1:0] gnt
);

  gnt_t                     r_gnt;
  gnt_t                     w_pick;
  logic                     r_last;
  logic [NB_MASTERS-1:0]    w_req;
  logic                     w_g0;
  logic                     w_g1;
  logic                     w_owner_cyc;
  logic [DATA_BYTES-1:0]    w_sel;
  logic [8*DATA_BYTES-1:0]  w_dat;

  assign w_req       = {wshb_ifs1.cyc, wshb_ifs0.cyc};
  assign w_g0        = (r_gnt == GNT_M0);
  assign w_g1        = (r_gnt == GNT_M1);
  assign w_owner_cyc = (w_g0 & wshb_ifs0.cyc) | (w_g1 & wshb_ifs1.cyc);

  wshb_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .i_req        (w_req),
    .i_last_served(r_last),
    .o_gnt        (w_pick)
  );

  // Re-arbitrate only when nobody holds the bus (idle, or the owner dropped cyc)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt  <= GNT_IDLE;
      r_last <= 1'b1;
    end else if (!w_owner_cyc) begin
      r_gnt <= w_pick;
      if (w_pick != GNT_IDLE) r_last <= (w_pick == GNT_M1);
    end
  end

  assign gnt = r_gnt;

  assign wshb_ifm.cyc    = (w_g0 & wshb_ifs0.cyc) | (w_g1 & wshb_ifs1.cyc);
  assign wshb_ifm.stb    = (w_g0 & wshb_ifs0.stb) | (w_g1 & wshb_ifs1.stb);
  // Idle bus presents master 0 fields; harmless because cyc is low
  assign wshb_ifm.adr    = w_g1 ? wshb_ifs1.adr : wshb_ifs0.adr;
  assign wshb_ifm.we     = w_g1 ? wshb_ifs1.we  : wshb_ifs0.we;
  assign w_sel           = w_g1 ? wshb_ifs1.sel : wshb_ifs0.sel;
  assign wshb_ifm.sel    = w_sel;
  assign w_dat           = w_g1 ? wshb_ifs1.dat_ms : wshb_ifs0.dat_ms;
  assign wshb_ifm.dat_ms = w_dat;
  assign wshb_ifm.cti    = w_g1 ? wshb_ifs1.cti : wshb_ifs0.cti;
  assign wshb_ifm.bte    = w_g1 ? wshb_ifs1.bte : wshb_ifs0.bte;

  assign wshb_ifs0.ack    = wshb_ifm.ack & w_g0;
  assign wshb_ifs1.ack    = wshb_ifm.ack & w_g1;
  assign wshb_ifs0.err    = wshb_ifm.err & w_g0;
  assign wshb_ifs1.err    = wshb_ifm.err & w_g1;
  assign wshb_ifs0.rty    = wshb_ifm.rty & w_g0;
  assign wshb_ifs1.rty    = wshb_ifm.rty & w_g1;
  assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
  assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: round-robin and fixed-priority instances against a bus-ownership model.
module tb_wshb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for both arbiter instances
  logic        c0 = 0, s0 = 0, we0 = 0, c1 = 0, s1 = 0, we1 = 0;
  logic [31:0] a0 = 0, a1 = 0, d0 = 0, d1 = 0, sdat = 0;
  logic [3:0]  sel0 = 0, sel1 = 0;
  logic [2:0]  cti0 = 0, cti1 = 0;
  logic [1:0]  bte0 = 0, bte1 = 0;
  logic        sack = 0, serr = 0, srty = 0;
  logic        mode = 0;   // 1: slave acks whenever it sees cyc&stb; 0: raw random ack

  logic [1:0]  gnt_rr, gnt_fp;
  int          n_vec = 0, n_mis = 0;
  bit          cmp_en = 0;

  wshb_if #(.DATA_BYTES(4)) m0_rr(), m1_rr(), s_rr(), m0_fp(), m1_fp(), s_fp();

  assign m0_rr.cyc = c0;  assign m0_rr.stb = s0;  assign m0_rr.we = we0;  assign m0_rr.adr = a0;
  assign m0_rr.sel = sel0; assign m0_rr.dat_ms = d0; assign m0_rr.cti = cti0; assign m0_rr.bte = bte0;
  assign m1_rr.cyc = c1;  assign m1_rr.stb = s1;  assign m1_rr.we = we1;  assign m1_rr.adr = a1;
  assign m1_rr.sel = sel1; assign m1_rr.dat_ms = d1; assign m1_rr.cti = cti1; assign m1_rr.bte = bte1;
  assign m0_fp.cyc = c0;  assign m0_fp.stb = s0;  assign m0_fp.we = we0;  assign m0_fp.adr = a0;
  assign m0_fp.sel = sel0; assign m0_fp.dat_ms = d0; assign m0_fp.cti = cti0; assign m0_fp.bte = bte0;
  assign m1_fp.cyc = c1;  assign m1_fp.stb = s1;  assign m1_fp.we = we1;  assign m1_fp.adr = a1;
  assign m1_fp.sel = sel1; assign m1_fp.dat_ms = d1; assign m1_fp.cti = cti1; assign m1_fp.bte = bte1;
  assign s_rr.ack = mode ? (s_rr.cyc & s_rr.stb) : sack;
  assign s_rr.err = serr; assign s_rr.rty = srty; assign s_rr.dat_sm = sdat;
  assign s_fp.ack = mode ? (s_fp.cyc & s_fp.stb) : sack;
  assign s_fp.err = serr; assign s_fp.rty = srty; assign s_fp.dat_sm = sdat;

  wshb_arbiter #(.FIXED_PRIO(1'b0), .DATA_BYTES(4)) dut_rr (
    .clk(clk), .rst(rst), .wshb_ifs0(m0_rr), .wshb_ifs1(m1_rr), .wshb_ifm(s_rr), .gnt(gnt_rr));
  wshb_arbiter #(.FIXED_PRIO(1'b1), .DATA_BYTES(4)) dut_fp (
    .clk(clk), .rst(rst), .wshb_ifs0(m0_fp), .wshb_ifs1(m1_fp), .wshb_ifm(s_fp), .gnt(gnt_fp));

  // Ownership model: owner index (-1 = nobody) and the last master granted
  int own_rr = -1, last_rr = 1, own_fp = -1, last_fp = 1;

  function automatic int pick(bit fp, bit r0, bit r1, int last);
    if (r0 && r1) return fp ? 0 : 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic bit holds(int own, bit r0, bit r1);
    return (own == 0 && r0) || (own == 1 && r1);
  endfunction

  function automatic int next_own(bit fp, int own, int last, bit r0, bit r1);
    return holds(own, r0, r1) ? own : pick(fp, r0, r1, last);
  endfunction

  function automatic int next_last(bit fp, int own, int last, bit r0, bit r1);
    int p;
    if (holds(own, r0, r1)) return last;
    p = pick(fp, r0, r1, last);
    return (p >= 0) ? p : last;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      own_rr <= -1; last_rr <= 1; own_fp <= -1; last_fp <= 1;
    end else begin
      own_rr  <= next_own(1'b0, own_rr, last_rr, c0, c1);
      last_rr <= next_last(1'b0, own_rr, last_rr, c0, c1);
      own_fp  <= next_own(1'b1, own_fp, last_fp, c0, c1);
      last_fp <= next_last(1'b1, own_fp, last_fp, c0, c1);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string t, input int own, input logic [1:0] g,
                     input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                     input logic [3:0] sel, input logic [31:0] dms, input logic [2:0] cti,
                     input logic [1:0] bte, input logic ack0, input logic ack1,
                     input logic err0, input logic err1, input logic rty0, input logic rty1,
                     input logic [31:0] dsm0, input logic [31:0] dsm1);
    logic ecyc, estb, eack;
    ecyc = (own == 0) ? c0 : (own == 1) ? c1 : 1'b0;
    estb = (own == 0) ? s0 : (own == 1) ? s1 : 1'b0;
    eack = mode ? (ecyc & estb) : sack;
    chk({t, "_gnt"}, 64'(g), (own == 0) ? 64'd1 : (own == 1) ? 64'd2 : 64'd0);
    chk({t, "_cyc"}, 64'(cyc), 64'(ecyc));
    chk({t, "_stb"}, 64'(stb), 64'(estb));
    chk({t, "_we"},  64'(we),  64'((own == 1) ? we1 : we0));
    chk({t, "_adr"}, 64'(adr), 64'((own == 1) ? a1 : a0));
    chk({t, "_sel"}, 64'(sel), 64'((own == 1) ? sel1 : sel0));
    chk({t, "_dms"}, 64'(dms), 64'((own == 1) ? d1 : d0));
    chk({t, "_cti_bte"}, 64'({cti, bte}), 64'((own == 1) ? {cti1, bte1} : {cti0, bte0}));
    chk({t, "_ack"}, 64'({ack1, ack0}), 64'({eack && own == 1, eack && own == 0}));
    chk({t, "_err"}, 64'({err1, err0}), 64'({serr && own == 1, serr && own == 0}));
    chk({t, "_rty"}, 64'({rty1, rty0}), 64'({srty && own == 1, srty && own == 0}));
    chk({t, "_dsm"}, 64'({dsm1, dsm0}), 64'({sdat, sdat}));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("rr", own_rr, gnt_rr, s_rr.cyc, s_rr.stb, s_rr.we, s_rr.adr, s_rr.sel, s_rr.dat_ms,
          s_rr.cti, s_rr.bte, m0_rr.ack, m1_rr.ack, m0_rr.err, m1_rr.err, m0_rr.rty, m1_rr.rty,
          m0_rr.dat_sm, m1_rr.dat_sm);
      cmp("fp", own_fp, gnt_fp, s_fp.cyc, s_fp.stb, s_fp.we, s_fp.adr, s_fp.sel, s_fp.dat_ms,
          s_fp.cti, s_fp.bte, m0_fp.ack, m1_fp.ack, m0_fp.err, m1_fp.err, m0_fp.rty, m1_fp.rty,
          m0_fp.dat_sm, m1_fp.dat_sm);
    end
  end

  task automatic idle_bus();
    @(posedge clk); #1;
    c0 = 0; s0 = 0; c1 = 0; s1 = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt0, cnt1, tack, k0, k1;
    bit dr0, dr1;
    logic [1:0] prev_g, g;
    logic [1:0] grants[$];

    // Reset with both requesting and a spurious ack: nothing may leak
    #1 rst = 1; c0 = 1; s0 = 1; c1 = 1; s1 = 1; sack = 1;
    @(posedge clk); #1;
    cmp_en = 1;
    @(negedge clk);
    chk("reset_gnt", 64'({gnt_rr, gnt_fp}), 64'd0);
    chk("reset_cyc", 64'({s_rr.cyc, s_rr.stb, s_fp.cyc}), 64'd0);
    chk("reset_ack", 64'({m0_rr.ack, m1_rr.ack, m0_fp.ack, m1_fp.ack}), 64'd0);

    // Contest at reset exit: master 0 wins first, master 1 takes over after 4 acks
    @(posedge clk); #1;
    rst = 0; sack = 0; mode = 1;
    @(posedge clk); #1;
    chk("contest_first_gnt", 64'(gnt_rr), 64'd1);
    cnt0 = 0;
    for (int i = 0; i < 20 && cnt0 < 4; i++) begin
      @(negedge clk);
      if (m0_rr.ack) cnt0++;
      if (cnt0 < 4) begin @(posedge clk); #1; end
    end
    chk("contest_acks_m0", 64'(cnt0), 64'd4);
    @(posedge clk); #1;
    c0 = 0; s0 = 0;
    @(posedge clk); #1;
    chk("handover_gnt", 64'(gnt_rr), 64'd2);
    idle_bus();

    // Spurious slave ack while idle
    mode = 0; sack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("leak_idle", 64'({gnt_rr, s_rr.cyc, m0_rr.ack, m1_rr.ack}), 64'd0);
    end
    sack = 0; mode = 1;

    // Single master: 64 writes from master 1
    @(posedge clk); #1;
    c1 = 1; s1 = 1; we1 = 1; a1 = 32'h1000;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 200 && cnt1 < 64; i++) begin
      @(negedge clk);
      chk("single_gnt", 64'(gnt_rr), (i == 0) ? 64'd0 : 64'd2);
      chk("single_adr", 64'(s_rr.adr), (i == 0) ? 64'(a0) : 64'(a1));
      if (m1_rr.ack) cnt1++;
      if (m0_rr.ack) cnt0++;
      @(posedge clk); #1;
      a1 = a1 + 32'd4;
    end
    chk("single_acks_m1", 64'(cnt1), 64'd64);
    chk("single_acks_m0", 64'(cnt0), 64'd0);
    idle_bus();

    // Round-robin bursts of 8, each master drops cyc for one cycle after its 8th ack
    c0 = 1; s0 = 1; c1 = 1; s1 = 1;
    k0 = 0; k1 = 0; dr0 = 0; dr1 = 0; tack = 0; prev_g = 2'b00;
    for (int i = 0; i < 300 && grants.size() < 4; i++) begin
      @(negedge clk);
      g = gnt_rr;
      if (g != prev_g) begin
        if (prev_g != 2'b00) chk("rr_tenure_acks", 64'(tack), 64'd8);
        if (g != 2'b00) grants.push_back(g);
        tack = 0;
        prev_g = g;
      end
      if (m0_rr.ack) begin k0++; tack++; end
      if (m1_rr.ack) begin k1++; tack++; end
      @(posedge clk); #1;
      if (dr0) begin c0 = 1; s0 = 1; dr0 = 0; k0 = 0; end
      else if (k0 == 8) begin c0 = 0; s0 = 0; dr0 = 1; end
      if (dr1) begin c1 = 1; s1 = 1; dr1 = 0; k1 = 0; end
      else if (k1 == 8) begin c1 = 0; s1 = 0; dr1 = 1; end
    end
    chk("rr_tenures", 64'(grants.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < grants.size()) ? 64'(grants[i]) : 64'd3, (i % 2 == 0) ? 64'd1 : 64'd2);
    idle_bus();

    // Fixed priority: master 1 keeps the bus while master 0 waits, then master 0 wins
    c1 = 1; s1 = 1;
    @(posedge clk); #1;
    c0 = 1; s0 = 1;
    repeat (5) begin
      @(negedge clk);
      chk("fp_hold_gnt", 64'(gnt_fp), 64'd2);
      chk("fp_wait_ack_m0", 64'(m0_fp.ack), 64'd0);
    end
    @(posedge clk); #1;
    c1 = 0; s1 = 0;
    @(posedge clk); #1;
    c1 = 1; s1 = 1;
    chk("fp_regrant_m0", 64'(gnt_fp), 64'd1);
    idle_bus();

    // Asynchronous reset in the middle of a master-0 read
    c0 = 1; s0 = 1; we0 = 0;
    @(posedge clk); #1;
    chk("areset_pre_gnt", 64'(gnt_rr), 64'd1);
    @(posedge clk); #3;
    rst = 1;
    #1;
    chk("areset_gnt", 64'({gnt_rr, gnt_fp}), 64'd0);
    chk("areset_bus", 64'({s_rr.cyc, s_rr.stb, s_fp.cyc, s_fp.stb}), 64'd0);
    chk("areset_ack", 64'({m0_rr.ack, m1_rr.ack, m0_fp.ack}), 64'd0);
    c1 = 1; s1 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("areset_exit_gnt", 64'({gnt_rr, gnt_fp}), 64'h5);

    // Randomised traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = 0;
      mode = (i / 256) % 2 == 1;
      if ($urandom_range(0, 7) == 0) c0 = ~c0;
      if ($urandom_range(0, 7) == 0) c1 = ~c1;
      s0 = c0 & ($urandom_range(0, 3) != 0);
      s1 = c1 & ($urandom_range(0, 3) != 0);
      a0 = $urandom(); a1 = $urandom(); d0 = $urandom(); d1 = $urandom();
      we0 = 1'($urandom()); we1 = 1'($urandom());
      sel0 = 4'($urandom()); sel1 = 4'($urandom());
      cti0 = 3'($urandom()); cti1 = 3'($urandom());
      bte0 = 2'($urandom()); bte1 = 2'($urandom());
      sack = 1'($urandom()); sdat = $urandom();
      serr = ($urandom_range(0, 15) == 0); srty = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin #2 rst = 1; end
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    cmp_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/wshb_arbiter.md
Name: wshb_arbiter

Overview:
- Two-master to one-slave Wishbone (classic, pipelined-free) arbiter sharing the single SDRAM Wishbone port between the VGA frame reader (master 0) and the test-pattern writer (master 1).
- Grants one master at a time, holds the grant for the master's whole cycle (cyc high), and re-arbitrates only when the owner drops cyc.
- Instantiated in the top level between the two masters and the SDRAM controller.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between masters; 1 = master 0 (VGA) always wins a contested decision.
- DATA_BYTES, 4, bytes per data word; width of the sel field, equal to the wshb_if sel width.

Ports:
- clk  input  1  system clock, same clock as all three interfaces.
- rst  input  1  reset; asynchronous, active-high.
- wshb_ifs0  wshb_if.slave  -  requester 0 (VGA reader), highest priority when FIXED_PRIO=1.
- wshb_ifs1  wshb_if.slave  -  requester 1 (pattern writer).
- wshb_ifm  wshb_if.master  -  shared port towards the SDRAM controller.
- gnt  output  2  one-hot current grant: bit i = master i owns the bus; 2'b00 = idle. Debug/visibility.

Behaviour:
- State register gnt: IDLE (00), OWN0 (01), OWN1 (10). Async reset -> IDLE; last_served -> 1, so master 0 wins the first contest.
- Decision point: rising edge where state is IDLE, or where the owner's cyc is 0.
- At a decision point:
  - Neither cyc high -> IDLE.
  - Exactly one cyc high -> grant that master.
  - Both high, FIXED_PRIO=1 -> grant master 0.
  - Both high, FIXED_PRIO=0 -> grant the master that is not last_served.
  - last_served updates to the granted index whenever a grant is issued.
- While the owner's cyc is 1, the grant is never changed, whatever the other master does. No preemption.
- Grant latency: one clock. A master raising cyc in cycle N with the bus idle sees its cyc/stb forwarded from cycle N+1.
- Handover: the owner drops cyc in cycle N and the other is requesting -> new grant visible in cycle N+1. No dead cycle beyond that, and no overlap.
- Owner drops cyc for one cycle and re-raises it:
  - Other master requesting -> re-arbitrated per the rule above; in round-robin, the other wins.
  - Otherwise the same master is re-granted.
- Slave-side outputs, combinational mux on registered gnt:
  - cyc, stb = granted master's cyc, stb AND'ed with its gnt bit; 0 in IDLE.
  - adr, we, sel, dat_ms, cti, bte come from the granted master. In IDLE they are driven from master 0 but qualified by cyc=0.
- Master-side outputs:
  - ack_i = wshb_ifm.ack & gnt[i].
  - dat_sm broadcast to both masters unconditionally.
  - err/rty, if present in wshb_if, gated like ack.
- A non-granted master sees ack=0 and waits with stb held; Wishbone requires it to keep its request stable.
- All outputs are 0 under reset: cyc, stb, ack to both masters, gnt.
- Reset mid-transfer: bus returns to IDLE asynchronously; the in-flight transfer is abandoned with no ack.
- Slave ack arriving in IDLE, which is illegal, is dropped and not forwarded.

Decomposition:
- Package wshb_arb_pkg holds:
  - typedef enum logic [1:0] {GNT_IDLE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10} gnt_t.
  - Constant NB_MASTERS = 2.
- One natural sub-module: wshb_arb_pick. It is the combinational decision function taking req[1:0], last_served and FIXED_PRIO and returning the next gnt_t. It is unit-testable on its own.
- Muxing and the state register stay in wshb_arbiter.

Test Plan:
- Single master: m1 holds cyc/stb for 64 writes with the slave acking every cycle -> gnt=10 from the 2nd cycle. 64 acks reach m1, 0 reach m0, and slave adr equals m1 adr each cycle.
- Contest at reset exit: both raise cyc in the same cycle, FIXED_PRIO=0 -> gnt=01 first. When m0 drops cyc after 4 acks, gnt=10 on the next edge.
- Round-robin: both keep requesting with bursts of 8, each dropping cyc 1 cycle after its 8th ack -> grants alternate 01,10,01,10. Each master gets exactly 8 acks per tenure.
- Fixed priority, FIXED_PRIO=1: m1 owns the bus mid-burst while m0 requests -> m1 keeps the grant until it drops cyc; then gnt=01 even if m1 re-raises cyc in that same cycle.
- No leakage: m0 idle (cyc=0) and the slave asserts a spurious ack while gnt=00 -> neither master sees ack, and wshb_ifm.cyc=0.
- Async reset mid-burst: rst asserted between clock edges during an m0 read -> gnt=00, wshb_ifm.cyc/stb=0 and acks=0 immediately, without waiting for a clock edge. After release with both requesting, gnt=01.
